// File: rtl/i2c_pkg.sv
// Shared I2C definitions: PHY bit-command codes and the byte controller state encoding.
package i2c_pkg;

  localparam logic [2:0] CMD_START = 3'd0;
  localparam logic [2:0] CMD_STOP  = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_NOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUS,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_RESP
  } ctrl_state_e;

endpackage

// File: rtl/i2c_master_byte_ctrl.sv
// Byte sequencer: one request (optional START, 8 data bits + ACK, optional STOP) becomes a stream of PHY
// bit commands; a single-cycle response pulse reports the result. Commands are held until the PHY reports done.
module i2c_master_byte_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned BUS_WAIT_TIMEOUT = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_start_i,
  input  logic       req_stop_i,
  input  logic       req_read_i,
  input  logic [7:0] req_wdata_i,
  input  logic       req_nack_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_nack_o,
  output logic       rsp_arb_lost_o,
  output logic       rsp_timeout_o,
  output logic       bus_owned_o,
  output logic [2:0] phy_cmd_o,
  output logic       phy_data_o,
  input  logic       phy_data_i,
  input  logic       phy_cmd_done_i,
  input  logic       phy_arb_lost_i,
  input  logic       phy_bus_busy_i
);

  localparam int unsigned TW_RAW = $clog2(BUS_WAIT_TIMEOUT + 1);
  localparam int unsigned TW     = (TW_RAW > 20) ? TW_RAW : 20;

  ctrl_state_e   state_q, state_n;
  logic [2:0]    cmd_q, cmd_n;
  logic          data_q, data_n;
  logic [7:0]    shift_q, shift_n;
  logic [2:0]    cnt_q, cnt_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          owned_q, owned_n;
  logic          arb_q, arb_n;
  logic          nack_q, nack_n;
  logic          stop_q, stop_n;
  logic          read_q, read_n;
  logic          rnack_q, rnack_n;
  logic          rsp_valid_q, rsp_valid_n;
  logic [7:0]    rsp_rdata_q, rsp_rdata_n;
  logic          rsp_nack_q, rsp_nack_n;
  logic          rsp_arb_q, rsp_arb_n;
  logic          rsp_to_q, rsp_to_n;
  logic          to_resp, resp_arb, resp_to, active;

  assign req_ready_o    = (state_q == ST_IDLE);
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_nack_o     = rsp_nack_q;
  assign rsp_arb_lost_o = rsp_arb_q;
  assign rsp_timeout_o  = rsp_to_q;
  assign bus_owned_o    = owned_q;
  assign phy_cmd_o      = cmd_q;
  assign phy_data_o     = data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_NOP;
      data_q      <= 1'b1;
      shift_q     <= 8'h00;
      cnt_q       <= 3'd0;
      timer_q     <= '0;
      owned_q     <= 1'b0;
      arb_q       <= 1'b0;
      nack_q      <= 1'b0;
      stop_q      <= 1'b0;
      read_q      <= 1'b0;
      rnack_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_nack_q  <= 1'b0;
      rsp_arb_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_n;
      cmd_q       <= cmd_n;
      data_q      <= data_n;
      shift_q     <= shift_n;
      cnt_q       <= cnt_n;
      timer_q     <= timer_n;
      owned_q     <= owned_n;
      arb_q       <= arb_n;
      nack_q      <= nack_n;
      stop_q      <= stop_n;
      read_q      <= read_n;
      rnack_q     <= rnack_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_nack_q  <= rsp_nack_n;
      rsp_arb_q   <= rsp_arb_n;
      rsp_to_q    <= rsp_to_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    cmd_n       = cmd_q;
    data_n      = data_q;
    shift_n     = shift_q;
    cnt_n       = cnt_q;
    timer_n     = timer_q;
    owned_n     = owned_q;
    arb_n       = arb_q;
    nack_n      = nack_q;
    stop_n      = stop_q;
    read_n      = read_q;
    rnack_n     = rnack_q;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = 8'h00;
    rsp_nack_n  = 1'b0;
    rsp_arb_n   = 1'b0;
    rsp_to_n    = 1'b0;
    to_resp     = 1'b0;
    resp_arb    = 1'b0;
    resp_to     = 1'b0;
    active      = (state_q == ST_START) || (state_q == ST_BIT) ||
                  (state_q == ST_ACK) || (state_q == ST_STOP);

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          stop_n  = req_stop_i;
          read_n  = req_read_i;
          rnack_n = req_nack_i;
          shift_n = req_read_i ? 8'h00 : req_wdata_i;
          cnt_n   = 3'd7;
          timer_n = '0;
          nack_n  = 1'b0;
          arb_n   = 1'b0;
          if (req_start_i) begin
            state_n = owned_q ? ST_START : ST_WAIT_BUS;
            cmd_n   = owned_q ? CMD_START : CMD_NOP;
            data_n  = 1'b1;
          end else begin
            state_n = ST_BIT;
            cmd_n   = req_read_i ? CMD_READ : CMD_WRITE;
            data_n  = req_read_i ? 1'b1 : req_wdata_i[7];
          end
        end
      end
      ST_WAIT_BUS: begin
        if (!phy_bus_busy_i) begin
          state_n = ST_START;
          cmd_n   = CMD_START;
          data_n  = 1'b1;
        end else if (BUS_WAIT_TIMEOUT != 0 && timer_q == TW'(BUS_WAIT_TIMEOUT - 1)) begin
          to_resp = 1'b1;
          resp_to = 1'b1;
        end else begin
          timer_n = timer_q + TW'(1);
        end
      end
      ST_START: begin
        if (phy_cmd_done_i) begin
          owned_n = 1'b1;
          state_n = ST_BIT;
          cmd_n   = read_q ? CMD_READ : CMD_WRITE;
          data_n  = read_q ? 1'b1 : shift_q[7];
        end
      end
      ST_BIT: begin
        if (phy_cmd_done_i) begin
          // One register serves both directions: write bits leave at the MSB while read bits enter at the LSB.
          shift_n = {shift_q[6:0], phy_data_i};
          if (cnt_q == 3'd0) begin
            state_n = ST_ACK;
            cmd_n   = read_q ? CMD_WRITE : CMD_READ;
            data_n  = read_q ? rnack_q : 1'b1;
          end else begin
            cnt_n  = cnt_q - 3'd1;
            cmd_n  = read_q ? CMD_READ : CMD_WRITE;
            data_n = read_q ? 1'b1 : shift_q[6];
          end
        end
      end
      ST_ACK: begin
        if (phy_cmd_done_i) begin
          nack_n = read_q ? rnack_q : phy_data_i;
          if (stop_q) begin
            state_n = ST_STOP;
            cmd_n   = CMD_STOP;
            data_n  = 1'b1;
          end else begin
            to_resp = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (phy_cmd_done_i) begin
          owned_n = 1'b0;
          to_resp = 1'b1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Arbitration loss overrides whatever the command completion above decided.
    if (phy_arb_lost_i) begin
      owned_n = 1'b0;
      if (active) arb_n = 1'b1;
    end
    if (active && phy_cmd_done_i && (arb_q || phy_arb_lost_i)) begin
      to_resp  = 1'b1;
      resp_arb = 1'b1;
      owned_n  = 1'b0;
    end

    if (to_resp) begin
      state_n     = ST_RESP;
      cmd_n       = CMD_NOP;
      data_n      = 1'b1;
      arb_n       = 1'b0;
      rsp_valid_n = 1'b1;
      rsp_rdata_n = read_q ? shift_n : 8'h00;
      rsp_nack_n  = nack_n;
      rsp_arb_n   = resp_arb;
      rsp_to_n    = resp_to;
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Randomized bench for i2c_master_byte_ctrl: a behavioural PHY (done 10 cycles after each command) logs the
// command stream, and expected streams/responses are built from transaction-level rules.
module tb_i2c_master_byte_ctrl;
  import i2c_pkg::*;

  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_start, req_stop, req_read, req_nack;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_nack, rsp_arb, rsp_to, bus_owned;
  logic [7:0] rsp_rdata;
  logic [2:0] phy_cmd;
  logic       phy_dout, phy_din, phy_done, phy_arb;
  logic       phy_busy;

  bit         model_busy, ext_busy;
  int         busy_cnt, cmd_idx, arb_idx, arb_at;
  logic [2:0] cur_cmd;
  logic       cur_dat;
  logic       rd_q[$];
  logic [3:0] log_q[$];
  logic [3:0] exp_q[$];

  int         n_checks, n_errors;
  bit         owned_exp;
  logic [7:0] g_rdata;
  logic       g_nack, g_arb, g_to;

  always #5 clk = ~clk;
  assign phy_busy = model_busy || ext_busy;

  i2c_master_byte_ctrl #(.BUS_WAIT_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_start_i(req_start), .req_stop_i(req_stop),
    .req_read_i(req_read), .req_wdata_i(req_wdata), .req_nack_i(req_nack),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_nack_o(rsp_nack), .rsp_arb_lost_o(rsp_arb),
    .rsp_timeout_o(rsp_to), .bus_owned_o(bus_owned),
    .phy_cmd_o(phy_cmd), .phy_data_o(phy_dout), .phy_data_i(phy_din), .phy_cmd_done_i(phy_done),
    .phy_arb_lost_i(phy_arb), .phy_bus_busy_i(phy_busy)
  );

  // Behavioural PHY: executes each command seen while idle, completes it 10 cycles later.
  initial begin
    phy_done = 1'b0; phy_arb = 1'b0; phy_din = 1'b1;
    busy_cnt = 0; model_busy = 0;
    forever begin
      @(negedge clk);
      phy_done = 1'b0;
      phy_arb  = 1'b0;
      if (rst) begin
        busy_cnt   = 0;
        model_busy = 0;
      end else if (busy_cnt == 0) begin
        if (phy_cmd != CMD_NOP) begin
          cur_cmd  = phy_cmd;
          cur_dat  = phy_dout;
          busy_cnt = 10;
        end
      end else begin
        busy_cnt--;
        if (cmd_idx == arb_idx && busy_cnt == arb_at) begin
          phy_arb    = 1'b1;
          model_busy = 0;
        end
        if (busy_cnt == 0) begin
          phy_done = 1'b1;
          log_q.push_back({cur_cmd, (cur_cmd == CMD_WRITE) ? cur_dat : 1'b0});
          cmd_idx++;
          if (cur_cmd == CMD_READ) phy_din = (rd_q.size() > 0) ? rd_q.pop_front() : 1'b1;
          if (cur_cmd == CMD_START) model_busy = 1;
          if (cur_cmd == CMD_STOP) model_busy = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected command stream and slave responses for one request, from the byte-transfer rules.
  task automatic prep(input bit st, input bit sp, input bit rd, input logic [7:0] wd, input bit nk,
                      input bit slave_nack, input logic [7:0] rbyte);
    exp_q.delete();
    rd_q.delete();
    log_q.delete();
    cmd_idx = 0;
    if (st) exp_q.push_back({CMD_START, 1'b0});
    for (int i = 7; i >= 0; i--) begin
      if (rd) begin
        exp_q.push_back({CMD_READ, 1'b0});
        rd_q.push_back(rbyte[i]);
      end else begin
        exp_q.push_back({CMD_WRITE, wd[i]});
      end
    end
    if (rd) exp_q.push_back({CMD_WRITE, nk});
    else begin
      exp_q.push_back({CMD_READ, 1'b0});
      rd_q.push_back(slave_nack);
    end
    if (sp) exp_q.push_back({CMD_STOP, 1'b0});
  endtask

  task automatic issue(input bit st, input bit sp, input bit rd, input logic [7:0] wd, input bit nk);
    req_start = st; req_stop = sp; req_read = rd; req_wdata = wd; req_nack = nk;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc, output bit ok);
    ok = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1;
        g_rdata = rsp_rdata; g_nack = rsp_nack; g_arb = rsp_arb; g_to = rsp_to;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic fin_txn(input string tag, input bit exp_arb, input bit exp_owned,
                         input logic [7:0] exp_rdata, input bit exp_nack);
    int cyc;
    bit ok;
    int n;
    wait_rsp(cyc, ok);
    chk({tag, "_rsp_seen"}, ok, 1);
    if (ok) begin
      chk({tag, "_rdata"}, g_rdata, exp_rdata);
      if (!exp_arb) chk({tag, "_nack"}, g_nack, exp_nack);
      chk({tag, "_arb"}, g_arb, exp_arb);
      chk({tag, "_timeout"}, g_to, 0);
      @(negedge clk);
      chk({tag, "_pulse"}, rsp_valid, 0);
    end
    repeat (15) @(negedge clk);
    chk({tag, "_owned"}, bus_owned, exp_owned);
    chk({tag, "_ncmds"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_cmd%0d", tag, i), log_q[i], exp_q[i]);
    owned_exp = exp_owned;
  endtask

  task automatic run_txn(input string tag, input bit st, input bit sp, input bit rd, input logic [7:0] wd,
                         input bit nk, input bit slave_nack, input logic [7:0] rbyte);
    bit new_owned;
    new_owned = sp ? 1'b0 : (st ? 1'b1 : owned_exp);
    prep(st, sp, rd, wd, nk, slave_nack, rbyte);
    issue(st, sp, rd, wd, nk);
    fin_txn(tag, 0, new_owned, rd ? rbyte : 8'h00, rd ? nk : slave_nack);
  endtask

  initial begin
    int cyc;
    bit ok;
    int start_cyc;
    n_checks = 0; n_errors = 0; owned_exp = 0;
    arb_idx = -1; arb_at = 5; cmd_idx = 0; ext_busy = 0;
    req_valid = 0; req_start = 0; req_stop = 0; req_read = 0; req_wdata = 8'h00; req_nack = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_cmd", phy_cmd, CMD_NOP);
    chk("rst_data", phy_dout, 1);
    chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_nack, rsp_arb, rsp_to}, 0);
    chk("rst_owned", bus_owned, 0);
    rst = 1'b0;
    @(negedge clk);

    run_txn("wr_a5", 1, 1, 0, 8'hA5, 0, 0, 8'h00);

    // Bus busy for 50 cycles before START may go out.
    ext_busy = 1;
    prep(1, 1, 0, 8'h5A, 0, 0, 8'h00);
    issue(1, 1, 0, 8'h5A, 0);
    start_cyc = -1;
    for (int c = 0; c < 400; c++) begin
      if (c == 50) ext_busy = 0;
      if (phy_cmd == CMD_START) begin
        start_cyc = c;
        break;
      end
      @(negedge clk);
    end
    chk("busw_start_lat", (start_cyc >= 50 && start_cyc <= 52), 1);
    fin_txn("busw", 0, 0, 8'h00, 0);

    // Bus never frees: timeout after BUS_WAIT_TIMEOUT cycles with nothing issued.
    ext_busy = 1;
    prep(1, 1, 0, 8'hFF, 0, 0, 8'h00);
    issue(1, 1, 0, 8'hFF, 0);
    wait_rsp(cyc, ok);
    chk("tmo_seen", ok, 1);
    chk("tmo_lat", (cyc >= 99 && cyc <= 101), 1);
    chk("tmo_flag", g_to, 1);
    chk("tmo_arb", g_arb, 0);
    repeat (100) @(negedge clk);
    ext_busy = 0;
    repeat (20) @(negedge clk);
    chk("tmo_ncmds", log_q.size(), 0);
    chk("tmo_owned", bus_owned, 0);

    run_txn("wr_nack", 1, 0, 0, 8'h3C, 0, 1, 8'h00);
    run_txn("rd_3c", 0, 1, 1, 8'h00, 1, 0, 8'h3C);

    // Arbitration loss mid-command, then coincident with a command completion.
    for (int k = 0; k < 2; k++) begin
      arb_idx = (k == 0) ? 4 : 3;
      arb_at  = (k == 0) ? 5 : 0;
      prep(1, 1, 0, 8'hC3, 0, 0, 8'h00);
      while (exp_q.size() > arb_idx + 1) void'(exp_q.pop_back());
      issue(1, 1, 0, 8'hC3, 0);
      fin_txn((k == 0) ? "arb_mid" : "arb_coinc", 1, 0, 8'h00, 0);
      arb_idx = -1;
    end

    // Reset in the middle of a byte.
    prep(1, 1, 0, 8'h96, 0, 0, 8'h00);
    issue(1, 1, 0, 8'h96, 0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready", req_ready, 1);
    chk("mrst_cmd", phy_cmd, CMD_NOP);
    chk("mrst_data", phy_dout, 1);
    chk("mrst_rsp", {rsp_valid, rsp_rdata, rsp_nack, rsp_arb, rsp_to}, 0);
    chk("mrst_owned", bus_owned, 0);
    rst = 1'b0;
    owned_exp = 0;
    @(negedge clk);
    run_txn("post_rst", 1, 1, 1, 8'h00, 0, 0, 8'h81);

    for (int t = 0; t < 20; t++) begin
      bit st, sp, rd, nk, sn;
      logic [7:0] wd, rb;
      st = owned_exp ? 1'($urandom_range(0, 1)) : 1'b1;
      sp = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      nk = 1'($urandom_range(0, 1));
      sn = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      rb = 8'($urandom);
      run_txn($sformatf("rnd%0d", t), st, sp, rd, wd, nk, sn, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
